// File: rtl/tlul_host_arb.sv
// -----------------------------------------------------------------------------
// tlul_pkg / tlul_host_arb
//
// Purpose:
//   Round-robin arbiter that shares one TL-UL device port among NumHosts TL-UL
//   hosts. A host wins ownership in IDLE, issues up to BurstMax requests
//   (never more than MaxOutstanding unanswered), then the arbiter drains all
//   outstanding responses before re-arbitrating, starting after the last owner.
//   Responses arriving with nothing outstanding are swallowed and flagged.
//
// Ports:
//   clk_i       in   clock, all state updates on rising edge
//   rst_ni      in   synchronous active-low reset
//   tl_h_i      in   [NumHosts] host A-channel requests / D-channel ready
//   tl_h_o      out  [NumHosts] host D-channel responses / A-channel ready
//   tl_d_o      out  shared device request
//   tl_d_i      in   shared device response
//   grant_o     out  one-hot current owner, all-zero when idle
//   busy_o      out  high while a host owns the device (GRANT or DRAIN)
//   spurious_o  out  one-cycle pulse, the cycle after a response arrived with
//                    nothing outstanding
// -----------------------------------------------------------------------------

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Idle host request: nothing issued, but always willing to accept a response.
    localparam tl_h2d_t TL_H2D_DEFAULT = '{d_ready: 1'b1, default: '0};

endpackage

module tlul_host_arb #(
    parameter int unsigned NumHosts       = 3,
    parameter int unsigned BurstMax       = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  tlul_pkg::tl_h2d_t    tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t    tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t    tl_d_o,
    input  tlul_pkg::tl_d2h_t    tl_d_i,
    output logic [NumHosts-1:0]  grant_o,
    output logic                 busy_o,
    output logic                 spurious_o
);

    localparam int unsigned IdxW  = $clog2(NumHosts);
    localparam int unsigned CntW  = 3;
    localparam int unsigned BcntW = $clog2(BurstMax + 1);

    localparam logic [CntW-1:0]  MaxOutC   = CntW'(MaxOutstanding);
    localparam logic [BcntW-1:0] BurstMaxC = BcntW'(BurstMax);
    localparam logic [IdxW-1:0]  LastHost  = IdxW'(NumHosts - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       ptr_q,   ptr_d;
    logic [CntW-1:0]       cnt_q,   cnt_d;
    logic [BcntW-1:0]      bcnt_q,  bcnt_d;
    logic [NumHosts-1:0]   grant_q, grant_d;
    logic                  busy_q,  busy_d;
    logic                  spurious_q, spurious_d;

    tlul_pkg::tl_h2d_t     own_req;
    logic                  a_gate;
    logic                  no_out;
    logic                  a_hs;
    logic                  d_hs;
    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;

    assign own_req = tl_h_i[owner_q];
    assign no_out  = (cnt_q == '0);

    // A traffic is only allowed while owning, below the in-flight limit and
    // with burst budget left.
    assign a_gate  = (state_q == GRANT) && (cnt_q < MaxOutC) && (bcnt_q < BurstMaxC);

    // Device request: owner's request passed straight through, valid gated.
    // With nothing outstanding the device response is consumed here, so
    // d_ready is forced high regardless of the owner.
    always_comb begin
        if (state_q == IDLE) begin
            tl_d_o = tlul_pkg::TL_H2D_DEFAULT;
        end else begin
            tl_d_o         = own_req;
            tl_d_o.a_valid = own_req.a_valid & a_gate;
            tl_d_o.d_ready = no_out | own_req.d_ready;
        end
    end

    // Host responses: only the owner sees the device, and only real
    // (counted) responses are delivered to it.
    always_comb begin
        for (int unsigned i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
            if ((state_q != IDLE) && (owner_q == IdxW'(i))) begin
                tl_h_o[i]         = tl_d_i;
                tl_h_o[i].a_ready = tl_d_i.a_ready & a_gate;
                tl_h_o[i].d_valid = tl_d_i.d_valid & ~no_out;
            end
        end
    end

    assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs = tl_d_i.d_valid & tl_d_o.d_ready & ~no_out;

    // Round-robin pick: first requester at or after ptr_q, wrapping.
    always_comb begin
        int unsigned     ptr_i;
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        ptr_i      = 32'(ptr_q);
        cand       = 0;
        cand_idx   = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NumHosts; k++) begin
            cand     = (ptr_i + k) % NumHosts;
            cand_idx = IdxW'(cand);
            if (!pick_valid && tl_h_i[cand_idx].a_valid) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        grant_d    = '0;
        busy_d     = 1'b0;
        spurious_d = tl_d_i.d_valid & no_out;

        if (a_hs && !d_hs) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!a_hs && d_hs) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (a_hs) begin
            bcnt_d = bcnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    bcnt_d  = '0;
                end
            end
            GRANT: begin
                // a_hs implies owner a_valid, so a low a_valid alone means
                // the owner has stopped issuing.
                if ((bcnt_d == BurstMaxC) || !own_req.a_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // cnt_d already accounts for a final response this cycle.
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    ptr_d   = (owner_q == LastHost) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        for (int unsigned i = 0; i < NumHosts; i++) begin
            grant_d[i] = busy_d && (owner_d == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_tlul_host_arb.sv
// -----------------------------------------------------------------------------
// tb_tlul_host_arb
//
// Randomized bench for tlul_host_arb. Hosts and device are driven from
// $urandom with per-phase probabilities; a transaction-level model tracks who
// owns the device, how many requests it has issued this grant, how many are
// unanswered, and whose turn is next, and predicts every DUT output each cycle.
// -----------------------------------------------------------------------------

module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int N  = 3;
    localparam int BM = 4;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    tl_h2d_t     h_req [N];
    tl_d2h_t     h_rsp [N];
    tl_h2d_t     d_req;
    tl_d2h_t     d_rsp;
    logic [N-1:0] grant;
    logic        busy;
    logic        spur;

    always #5 clk = ~clk;

    tlul_host_arb #(
        .NumHosts       (N),
        .BurstMax       (BM),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tl_h_i     (h_req),
        .tl_h_o     (h_rsp),
        .tl_d_o     (d_req),
        .tl_d_i     (d_rsp),
        .grant_o    (grant),
        .busy_o     (busy),
        .spurious_o (spur)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: owner (-1 = nobody), issued this grant, unanswered,
    // whether the owner has finished issuing, next turn, pending spurious flag.
    int m_owner    = -1;
    int m_issued   = 0;
    int m_inflight = 0;
    int m_next     = 0;
    bit m_done     = 1'b0;
    bit m_spur     = 1'b0;

    bit acc [N];
    int p_req, p_ar, p_dv, p_dr, p_rst;

    task automatic drive_inputs(input bit force_rst);
        logic [95:0] r;
        for (int h = 0; h < N; h++) begin
            // A host keeps an unaccepted request stable.
            if (!(h_req[h].a_valid && !acc[h])) begin
                r = {$urandom(), $urandom(), $urandom()};
                h_req[h] = tl_h2d_t'(r[85:0]);
                h_req[h].a_valid = ($urandom_range(0, 99) < p_req);
            end
            h_req[h].d_ready = ($urandom_range(0, 99) < p_dr);
        end
        r = {$urandom(), $urandom(), $urandom()};
        d_rsp = tl_d2h_t'(r[51:0]);
        d_rsp.a_ready = ($urandom_range(0, 99) < p_ar);
        d_rsp.d_valid = ($urandom_range(0, 99) < p_dv);
        rst_n = force_rst ? 1'b0 : ($urandom_range(0, 999) >= p_rst);
    endtask

    task automatic one_cycle(input bit force_rst);
        int      o;
        bit      may_issue, a_acc, d_acc, nspur;
        tl_h2d_t e_dreq;
        tl_d2h_t e_rsp;
        logic [N-1:0] e_grant;

        @(negedge clk);
        o = m_owner;
        may_issue = (o >= 0) && !m_done && (m_inflight < MO) && (m_issued < BM);

        if (o < 0) begin
            e_dreq = TL_H2D_DEFAULT;
        end else begin
            e_dreq         = h_req[o];
            e_dreq.a_valid = h_req[o].a_valid && may_issue;
            e_dreq.d_ready = (m_inflight == 0) || h_req[o].d_ready;
        end
        check("dev_req", 128'(d_req), 128'(e_dreq));

        for (int h = 0; h < N; h++) begin
            e_rsp = '0;
            if (h == o) begin
                e_rsp         = d_rsp;
                e_rsp.a_ready = d_rsp.a_ready && may_issue;
                e_rsp.d_valid = d_rsp.d_valid && (m_inflight > 0);
            end
            check($sformatf("host%0d_rsp", h), 128'(h_rsp[h]), 128'(e_rsp));
        end

        e_grant = '0;
        if (o >= 0) e_grant[o] = 1'b1;
        check("grant", 128'(grant), 128'(e_grant));
        check("busy", 128'(busy), 128'(o >= 0));
        check("spurious", 128'(spur), 128'(m_spur));

        a_acc = e_dreq.a_valid && d_rsp.a_ready;
        d_acc = d_rsp.d_valid && e_dreq.d_ready && (m_inflight > 0);
        nspur = d_rsp.d_valid && (m_inflight == 0);

        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_issued = 0; m_inflight = 0; m_next = 0;
            m_done = 1'b0; m_spur = 1'b0;
            for (int h = 0; h < N; h++) acc[h] = 1'b0;
        end else begin
            m_spur = nspur;
            for (int h = 0; h < N; h++) acc[h] = (h == o) && a_acc;
            if (o < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && h_req[(m_next + k) % N].a_valid) begin
                        m_owner  = (m_next + k) % N;
                        m_issued = 0;
                        m_done   = 1'b0;
                    end
                end
            end else begin
                m_inflight = m_inflight + int'(a_acc) - int'(d_acc);
                m_issued   = m_issued + int'(a_acc);
                if (!m_done) begin
                    if (m_issued == BM || !h_req[o].a_valid) m_done = 1'b1;
                end else if (m_inflight == 0) begin
                    m_next  = (o + 1) % N;
                    m_owner = -1;
                end
            end
        end
        #1;
        drive_inputs(force_rst);
    endtask

    task automatic run_phase(input int cycles, input int req, input int ar,
                             input int dv, input int dr, input int rst_pm);
        p_req = req; p_ar = ar; p_dv = dv; p_dr = dr; p_rst = rst_pm;
        for (int c = 0; c < cycles; c++) one_cycle(1'b0);
    endtask

    initial begin
        for (int h = 0; h < N; h++) begin
            h_req[h] = TL_H2D_DEFAULT;
            acc[h]   = 1'b0;
        end
        p_req = 0; p_ar = 0; p_dv = 0; p_dr = 0; p_rst = 0;
        d_rsp = '0;
        rst_n = 1'b0;

        // Held reset with busy inputs: everything must stay quiet.
        p_req = 100; p_dv = 100; p_ar = 100;
        for (int c = 0; c < 4; c++) one_cycle(1'b1);

        // All hosts always requesting, device always ready and answering.
        run_phase(200, 100, 100, 100, 100, 0);
        // General traffic.
        run_phase(1500, 60, 70, 40, 80, 0);
        // Slow responses: in-flight limit stalls the owner.
        run_phase(800, 80, 100, 5, 100, 0);
        // Mixed traffic with occasional mid-transaction resets.
        run_phase(1500, 50, 50, 50, 50, 20);
        // Sparse requests, frequent unsolicited responses.
        run_phase(500, 10, 60, 50, 60, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
